// File: rtl/core_fetch_prefetch_pkg.sv
// Shared types for the fetch front end.
//   ptr_t         : 30-bit word address
//   word_t        : 32-bit instruction word
//   fetch_state_t : request tracking state (IDLE / WAIT / DISCARD)
//   fetch_entry_t : one prefetch FIFO entry, {pc, data}
package core_fetch_prefetch_pkg;

  localparam int PTR_W  = 30;
  localparam int WORD_W = 32;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [WORD_W-1:0] word_t;

  // IDLE    : no request outstanding
  // WAIT    : request outstanding, its response will be kept
  // DISCARD : request outstanding, its response will be dropped (redirected)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    ptr_t  pc;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_prefetch_if.sv
// Bus and decode-side signals of the fetch front end.
//   fetch_start/fetch_addr : request to the instruction bus (one-cycle pulse,
//                            address held until the response)
//   fetch_ready/fetch_data : bus response, data valid with fetch_ready
//   insn_valid/insn_ready  : decode handshake; insn/insn_pc are the head word
// Handshake: a head word transfers on a cycle where insn_valid && insn_ready;
// insn_valid never depends on insn_ready, and insn/insn_pc are meaningless
// while insn_valid is low.
interface core_fetch_prefetch_if;
  import core_fetch_prefetch_pkg::*;

  logic  fetch_start;
  ptr_t  fetch_addr;
  logic  fetch_ready;
  word_t fetch_data;
  logic  insn_valid;
  logic  insn_ready;
  word_t insn;
  ptr_t  insn_pc;

  // master: the fetch unit
  modport master (
    output fetch_start, fetch_addr, insn_valid, insn, insn_pc,
    input  fetch_ready, fetch_data, insn_ready
  );

  // slave: bus + decode environment
  modport slave (
    input  fetch_start, fetch_addr, insn_valid, insn, insn_pc,
    output fetch_ready, fetch_data, insn_ready
  );

endinterface

// File: rtl/core_fetch_prefetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, data}.
//   clk, rst  : clock, synchronous active-high reset
//   push/wr_entry : write an entry at the tail
//   pop       : drop the head entry
//   flush     : clear the FIFO; wins over push and pop
//   head/valid: head entry and non-empty flag
//   count     : number of stored entries (log2(DEPTH)+1 bits)
module core_fetch_fifo
  import core_fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  fetch_entry_t mem_q [DEPTH];

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign push_ok = push && !flush && (count_q != IDX_W'(0) + (IDX_W+1)'(DEPTH));
  assign pop_ok  = pop  && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/core_fetch_prefetch.sv
// Fetch front end. Tracks the fetch PC, issues one word fetch at a time on
// the instruction bus, buffers returned words with their PCs and hands the
// FIFO head to decode. A branch flushes the FIFO, drops any in-flight
// response and redirects fetch_pc to branch_target.
//   clk, rst              : clock, synchronous active-high reset
//   branch/branch_target  : one-cycle redirect and its word address
//   bus (master)          : fetch request/response and decode handshake
//   dbg_state             : current request-tracking state
module core_fetch_prefetch
  import core_fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch,
  input  ptr_t                  branch_target,
  core_fetch_prefetch_if.master bus,
  output fetch_state_t          dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t state_q, state_d;
  ptr_t         fetch_pc_q, fetch_pc_d;
  ptr_t         fetch_addr_q, fetch_addr_d;
  logic         fetch_start_q, fetch_start_d;

  logic             issue, push, pop, outstanding;
  logic [CNT_W:0]   reserved;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  fetch_entry_t     fifo_head, fifo_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      fetch_addr_q  <= '0;
      fetch_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_start_q <= fetch_start_d;
    end
  end

  // FSM outputs. An outstanding request reserves a FIFO slot, so a
  // response can always be pushed without overflow.
  always_comb begin
    outstanding = (state_q != IDLE);
    reserved    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};
    issue       = (state_q == IDLE) && !branch && (reserved < (CNT_W+1)'(DEPTH));
    push        = (state_q == WAIT) && bus.fetch_ready && !branch;
    pop         = fifo_valid && bus.insn_ready && !branch;
  end

  // Next state. A branch while a request is in flight turns the pending
  // response into one that is dropped; it still has to be waited out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT: begin
        if (bus.fetch_ready)  state_d = IDLE;
        else if (branch)      state_d = DISCARD;
      end
      DISCARD: if (bus.fetch_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PC / bus address. fetch_addr only moves on issue, so it stays stable
  // across the whole request even if a branch arrives.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_addr_d  = fetch_addr_q;
    fetch_start_d = issue;
    if (branch)    fetch_pc_d = branch_target;
    else if (push) fetch_pc_d = fetch_addr_q + 1'b1;
    if (issue)     fetch_addr_d = fetch_pc_q;
  end

  assign fifo_in = '{pc: fetch_addr_q, data: bus.fetch_data};

  core_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (branch),
    .wr_entry (fifo_in),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign bus.fetch_start = fetch_start_q;
  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.insn_valid  = fifo_valid;
  assign bus.insn        = fifo_head.data;
  assign bus.insn_pc     = fifo_head.pc;
  assign dbg_state       = state_q;

endmodule
